// File: rtl/bytecode_fetch.sv
// Bytecode prefetch and issue stage: fills a small byte FIFO from program memory,
// assembles opcode+operand words and hands them to the decoder via start/ready.
module bytecode_fetch #(
  parameter int BYTE   = 8,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                pc_load,
  input  logic [ADDR_W-1:0]   pc_load_value,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [BYTE-1:0]     mem_rdata,
  input  logic                dec_ready,
  output logic                dec_start,
  output logic [2*BYTE-1:0]   instruction_out,
  output logic [ADDR_W-1:0]   pc_out,
  output logic [2:0]          fifo_level,
  output logic                busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W:0] DEPTH_C = (LVL_W+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  // Opcodes that carry a one-byte immediate/index operand.
  function automatic logic two_byte(input logic [BYTE-1:0] op);
    logic [7:0] o;
    o = op[7:0];
    return (o == 8'h10) || (o == 8'h12) ||
           (o >= 8'h15 && o <= 8'h19) ||
           (o >= 8'h36 && o <= 8'h3A) ||
           (o == 8'hBC);
  endfunction

  logic [BYTE-1:0]     fifo_q [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_nx;
  logic [LVL_W-1:0]    level_q, level_d, pop_n;
  logic                inflight_q, inflight_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   issue_pc_q, issue_pc_d;
  logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
  logic [2*BYTE-1:0]   instr_q, instr_d;
  logic                dec_start_q, dec_start_d;
  state_t              state_q, state_d;

  logic                rd_go, push, pop, head_two, can_issue;
  logic [BYTE-1:0]     head, next_byte;

  // Occupancy counts the outstanding read so the FIFO can never overflow.
  assign rd_go = reset && enable && !pc_load &&
                 ((LVL_W+1)'(level_q) + (LVL_W+1)'(inflight_q) < DEPTH_C);
  // A jump drops the byte returning this cycle; it belongs to the old stream.
  assign push      = inflight_q && !pc_load;
  assign rd_ptr_nx = rd_ptr_q + PTR_W'(1);
  assign head      = fifo_q[rd_ptr_q];
  assign next_byte = fifo_q[rd_ptr_nx];
  assign head_two  = two_byte(head);
  assign can_issue = (level_q >= LVL_W'(1)) &&
                     (!head_two || level_q >= LVL_W'(2)) && dec_ready;

  always_comb begin
    state_d     = state_q;
    dec_start_d = 1'b0;
    instr_d     = instr_q;
    pc_out_d    = pc_out_q;
    issue_pc_d  = issue_pc_q;
    pop         = 1'b0;
    case (state_q)
      IDLE:      if (enable) state_d = CHECK;
      CHECK: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (!pc_load && can_issue) begin
          state_d     = ISSUE;
          dec_start_d = 1'b1;
          instr_d     = {head, head_two ? next_byte : {BYTE{1'b0}}};
          pc_out_d    = issue_pc_q;
          pop         = 1'b1;
          issue_pc_d  = issue_pc_q + (head_two ? ADDR_W'(2) : ADDR_W'(1));
        end
      end
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (!dec_ready) state_d = WAIT_DONE;
      WAIT_DONE: if (dec_ready) state_d = CHECK;
      default:   state_d = IDLE;
    endcase
    if (pc_load) issue_pc_d = pc_load_value;
  end

  always_comb begin
    pop_n      = pop ? (head_two ? LVL_W'(2) : LVL_W'(1)) : '0;
    inflight_d = rd_go;
    fetch_pc_d = fetch_pc_q;
    if (pc_load)    fetch_pc_d = pc_load_value;
    else if (rd_go) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
    level_d  = level_q + LVL_W'(push) - pop_n;
    if (pc_load) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) fifo_q[wr_ptr_q] <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      inflight_q  <= 1'b0;
      fetch_pc_q  <= '0;
      issue_pc_q  <= '0;
      pc_out_q    <= '0;
      instr_q     <= '0;
      dec_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      inflight_q  <= inflight_d;
      fetch_pc_q  <= fetch_pc_d;
      issue_pc_q  <= issue_pc_d;
      pc_out_q    <= pc_out_d;
      instr_q     <= instr_d;
      dec_start_q <= dec_start_d;
    end
  end

  assign mem_rd_en       = rd_go;
  assign mem_addr        = rd_go ? fetch_pc_q : '0;
  assign dec_start       = dec_start_q;
  assign instruction_out = instr_q;
  assign pc_out          = pc_out_q;
  assign fifo_level      = 3'(level_q);
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_bytecode_fetch.sv
// Directed bench for bytecode_fetch: byte memory model, decoder handshake model,
// and a scoreboard of expected issued words checked by an independent monitor.
module tb_bytecode_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_value = '0;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic        dec_ready;
  logic        dec_start;
  logic [15:0] instruction_out;
  logic [15:0] pc_out;
  logic [2:0]  fifo_level;
  logic        busy;

  typedef struct { logic [15:0] instr; logic [15:0] pc; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int rd_count = 0;

  logic [7:0] pmem [65536];
  logic       model_rdy = 1'b1;
  int         dcnt = 0;
  logic       hold_ready = 1'b0;

  bytecode_fetch dut (
    .clk(clk), .reset(reset), .enable(enable), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .dec_ready(dec_ready), .dec_start(dec_start),
    .instruction_out(instruction_out), .pc_out(pc_out),
    .fifo_level(fifo_level), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous byte memory: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= pmem[mem_addr];
      rd_count++;
    end
  end

  // Decoder: ready drops the cycle after start, returns two cycles later.
  always @(posedge clk) begin
    if (dec_start) begin
      model_rdy <= 1'b0;
      dcnt      <= 2;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) model_rdy <= 1'b1;
    end
  end
  assign dec_ready = model_rdy & ~hold_ready;

  always @(negedge clk) begin
    exp_t e;
    if (dec_start) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected issue instr=%h pc=%h (none expected)", instruction_out, pc_out);
      end else begin
        e = sb.pop_front();
        if (instruction_out !== e.instr || pc_out !== e.pc) begin
          errors++;
          $display("FAIL sb_issue actual instr=%h pc=%h expected instr=%h pc=%h",
                   instruction_out, pc_out, e.instr, e.pc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expect_issue(input logic [15:0] instr, input logic [15:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    sb.push_back(e);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) pmem[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; enable = 1'b0; pc_load = 1'b0; hold_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rd_count = 0;
  endtask

  // Wait for the scoreboard to drain, then stop issuing.
  task automatic drain_and_stop(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk(name, sb.size(), 0);
    enable = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_start(input string name, input int bound, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (dec_start) begin seen = 1'b1; break; end
    end
    chk(name, seen, 1'b1);
  endtask

  initial begin
    logic seen;
    clear_mem();

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_start", dec_start, 0);
    chk("rst_instr", instruction_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);

    // 1: three 1-byte opcodes
    clear_mem();
    pmem[0] = 8'h03; pmem[1] = 8'h04; pmem[2] = 8'h60;
    expect_issue(16'h0300, 16'h0000);
    expect_issue(16'h0400, 16'h0001);
    expect_issue(16'h6000, 16'h0002);
    enable = 1'b1;
    drain_and_stop("t1_drain", 60);
    do_reset();

    // 2: two-byte opcodes assembled with operands
    clear_mem();
    pmem[0] = 8'h10; pmem[1] = 8'h7F; pmem[2] = 8'h18; pmem[3] = 8'h05;
    expect_issue(16'h107F, 16'h0000);
    expect_issue(16'h1805, 16'h0002);
    enable = 1'b1;
    drain_and_stop("t2_drain", 60);
    do_reset();

    // 3: decoder held busy, FIFO fills, then refill after the first pop
    clear_mem();
    for (int i = 0; i < 8; i++) pmem[i] = 8'(i + 1);
    hold_ready = 1'b1;
    enable = 1'b1;
    repeat (10) @(negedge clk);
    chk("t3_reads", rd_count, 4);
    chk("t3_level", fifo_level, 4);
    chk("t3_rd_stalled", mem_rd_en, 0);
    expect_issue(16'h0100, 16'h0000);
    hold_ready = 1'b0;
    wait_start("t3_start", 10, seen);
    chk("t3_refill_en", mem_rd_en, 1);
    chk("t3_refill_addr", mem_addr, 16'h0004);
    chk("t3_level_after_pop", fifo_level, 3);
    enable = 1'b0;
    repeat (8) @(negedge clk);
    chk("t3_sb_empty", sb.size(), 0);
    do_reset();

    // 4: jump while a read is in flight and 3 bytes buffered
    clear_mem();
    for (int i = 0; i < 8; i++) pmem[i] = 8'(i + 1);
    pmem[16'h0100] = 8'h05;
    hold_ready = 1'b1;
    enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_level == 3) begin seen = 1'b1; break; end
    end
    chk("t4_level3", seen, 1);
    chk("t4_rd_idle_inflight", mem_rd_en, 0);
    pc_load = 1'b1; pc_load_value = 16'h0100;
    @(negedge clk);
    pc_load = 1'b0;
    #1;
    chk("t4_flush_level", fifo_level, 0);
    chk("t4_rd_en", mem_rd_en, 1);
    chk("t4_addr", mem_addr, 16'h0100);
    expect_issue(16'h0500, 16'h0100);
    hold_ready = 1'b0;
    drain_and_stop("t4_drain", 40);
    do_reset();

    // 5: address wrap at the top of memory
    clear_mem();
    pmem[16'hFFFF] = 8'h07; pmem[0] = 8'h08;
    expect_issue(16'h0700, 16'hFFFF);
    expect_issue(16'h0800, 16'h0000);
    @(negedge clk);
    enable = 1'b1; pc_load = 1'b1; pc_load_value = 16'hFFFF;
    #1;
    chk("t5_no_rd_on_load", mem_rd_en, 0);
    @(negedge clk);
    pc_load = 1'b0;
    #1;
    chk("t5_rd_a", mem_rd_en, 1);
    chk("t5_addr_a", mem_addr, 16'hFFFF);
    @(negedge clk);
    chk("t5_rd_b", mem_rd_en, 1);
    chk("t5_addr_b", mem_addr, 16'h0000);
    drain_and_stop("t5_drain", 60);
    do_reset();

    // 6: reset asserted in WAIT_DONE with buffered bytes
    clear_mem();
    for (int i = 0; i < 8; i++) pmem[i] = 8'(i + 1);
    expect_issue(16'h0100, 16'h0000);
    enable = 1'b1;
    wait_start("t6_start", 20, seen);
    repeat (2) @(negedge clk);
    chk("t6_busy_pre", busy, 1);
    chk("t6_level_nonzero", (fifo_level != 0), 1);
    reset = 1'b0; enable = 1'b0;
    @(negedge clk);
    chk("t6_rd_en", mem_rd_en, 0);
    chk("t6_addr", mem_addr, 0);
    chk("t6_start", dec_start, 0);
    chk("t6_instr", instruction_out, 0);
    chk("t6_pc", pc_out, 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_busy", busy, 0);
    reset = 1'b1;
    repeat (6) @(negedge clk);

    chk("sb_leftover", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bytecode_fetch.md
Name: bytecode_fetch

Overview:
Upstream feeder for the bytecode decoder. Prefetches JVM bytecode bytes from byte-wide program memory into a small FIFO. Assembles each instruction (opcode byte plus an optional one-byte operand) into a 16-bit word. Hands the word to the decoder with a start/ready handshake and tracks the bytecode PC, including jump reloads.

Parameters:
BYTE, 8, byte width
ADDR_W, 16, program address width
DEPTH, 4, prefetch FIFO depth in bytes (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
enable  in  1  run fetch and issue; 0 = hold (no new reads, no new issues)
pc_load  in  1  one-cycle jump request
pc_load_value  in  ADDR_W  jump target
mem_rd_en  out  1  program memory read strobe
mem_addr  out  ADDR_W  program memory byte address
mem_rdata  in  BYTE  read data, valid the cycle after mem_rd_en
dec_ready  in  1  decoder idle (WAIT state)
dec_start  out  1  one-cycle pulse: instruction_out valid
instruction_out  out  2*BYTE  [15:8]=opcode, [7:0]=operand or 0
pc_out  out  ADDR_W  address of the opcode currently presented
fifo_level  out  3  bytes held in FIFO (0..DEPTH)
busy  out  1  issue FSM not in IDLE

Behaviour:
- Reset is clk-sampled with reset==0. All of the following are 0: fetch_pc, issue_pc, FIFO pointers/level, the in-flight flag, mem_rd_en, mem_addr, dec_start, instruction_out, pc_out, busy. Issue FSM = IDLE.
- Fetch side:
  - Condition: enable && !pc_load && (fifo_level + inflight) < DEPTH.
  - When true: mem_rd_en=1, mem_addr=fetch_pc, fetch_pc+=1, inflight<=1.
  - Next cycle: mem_rdata is pushed and inflight clears, unless it was invalidated.
  - fetch_pc wraps at 2^ADDR_W-1 -> 0.
- Instruction length:
  - 2 bytes for opcodes 0x10 bipush, 0x12 ldc, 0x15-0x19 loads, 0x36-0x3A stores, 0xBC newarray.
  - 1 byte for all other opcodes; operand byte forced to 0.
- Issue FSM: IDLE, CHECK, ISSUE, WAIT_BUSY, WAIT_DONE.
  - IDLE -> CHECK when enable=1.
  - CHECK -> IDLE when enable=0.
  - CHECK -> ISSUE when fifo_level>=1, fifo_level>=len(head), and dec_ready=1. On this transition:
    - register instruction_out and pc_out=issue_pc;
    - pop len bytes;
    - issue_pc+=len.
  - ISSUE: dec_start=1 for exactly this cycle -> WAIT_BUSY.
  - WAIT_BUSY: wait for dec_ready==0 -> WAIT_DONE.
  - WAIT_DONE: wait for dec_ready==1 -> CHECK.
  - instruction_out holds its value until the next ISSUE.
- Latency: a 1-byte instruction at an empty FIFO with dec_ready=1 gives dec_start 3 cycles after the mem_rd_en that fetches it (read, push, CHECK->ISSUE).
- Simultaneous push and pop in one cycle: allowed; fifo_level changes by (push - popped bytes).
- Full: no reads issued while level+inflight==DEPTH.
- Empty, or 2-byte opcode with only 1 byte present: remain in CHECK, no pulse.
- pc_load (priority over everything except reset):
  - flush FIFO (level=0) and invalidate the in-flight return (discarded next cycle);
  - fetch_pc=issue_pc=pc_load_value;
  - no mem_rd_en that cycle.
  - FSM in CHECK stays in CHECK. FSM in ISSUE/WAIT_* completes the handshake normally, since that instruction is already with the decoder.
- enable=0 mid-handshake: the FSM finishes WAIT_BUSY/WAIT_DONE, then CHECK -> IDLE. A pending in-flight read is still pushed.
- Reset mid-operation: returns immediately to reset values and drops any in-flight data.

Test Plan:
1. Memory [0]=0x03,[1]=0x04,[2]=0x60; enable=1; decoder model (ready drops 1 cycle after start, returns 2 cycles later) -> three dec_start pulses with instruction_out 0x0300, 0x0400, 0x6000 and pc_out 0,1,2.
2. Memory [0]=0x10,[1]=0x7F,[2]=0x18,[3]=0x05 -> instruction_out 0x107F at pc_out 0, then 0x1805 at pc_out 2; never a 1-byte issue of 0x10.
3. Hold dec_ready=0 -> mem_rd_en stops after 4 reads and fifo_level=4; no dec_start. Release -> issues resume, refill starts the cycle after the first pop.
4. pc_load=1, pc_load_value=0x0100 while a read is in flight and FIFO holds 3 bytes -> fifo_level=0 next cycle, stale byte discarded, next mem_addr=0x0100, next pc_out=0x0100.
5. fetch_pc=0xFFFF with 1-byte opcodes -> mem_addr sequence 0xFFFF, 0x0000; pc_out wraps identically.
6. reset=0 during WAIT_DONE with FIFO non-empty -> next cycle all outputs 0, fifo_level=0, busy=0, no dec_start.
